clk_div_multi: RTL and testbench
================================

Name: clk_div_multi

Overview:
- Parametrised multi-channel clock divider. Generates NUM_CH independent 50%-duty divided clocks and single-cycle tick strobes from the system clock.
- Each channel has a runtime-programmable divisor and its own enable. Divisor changes are glitch-free.
- Feeds slow-rate consumers (serial links, display scan, sampling strobes) from one block instead of one fixed divider per rate.

Parameters:
- NUM_CH, 4, number of independent channels.
- CNT_W, 10, counter and divisor width per channel.
- DIV_DEFAULT, 750, divisor loaded into every channel at reset (toggle period 2*(DIV_DEFAULT+1) cycles).
- TCNT_W, 16, tick-counter width; used only with TICK_CNT_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous active-low reset (0 = reset).
- en  in  NUM_CH  per-channel enable.
- div_in  in  NUM_CH*CNT_W  packed divisors; channel i at bits [i*CNT_W +: CNT_W].
- div_load  in  NUM_CH  1-cycle strobe; captures div_in slice i into channel i pending register.
- sync_clr  in  1  synchronous phase-align of all channels.
- clk_out  out  NUM_CH  divided clocks, registered.
- tick  out  NUM_CH  1-cycle strobe at each terminal count, registered.
- tick_cnt  out  NUM_CH*TCNT_W  present only with TICK_CNT_EN.

Behaviour:
- Reset (rst=0, asynchronous): cnt=0, active_div=pending_div=DIV_DEFAULT, clk_out=0, tick=0, tick_cnt=0.
- Per channel, enabled, no sync_clr:
  - Counter runs 0..active_div.
  - Terminal count (cnt==active_div): next cycle cnt=0, clk_out toggles, tick=1 for exactly one cycle.
  - Otherwise cnt increments, clk_out holds, tick=0.
- Period: clk_out period = 2*(active_div+1) cycles; tick period = active_div+1 cycles.
- Edge latency: tick and the clk_out edge appear in the same cycle, one cycle after cnt==active_div is sampled.
- active_div=0: tick stuck high, clk_out toggles every cycle (divide-by-2).
- Divisor update:
  - div_load writes pending_div.
  - active_div <= pending_div only at terminal count or while en=0, so no shortened or stretched half-period.
  - div_load coincident with terminal count: the new div_in goes directly to active_div for the next period.
  - Multiple div_load strobes before a terminal count: last one wins.
- en=0: next cycle cnt=0, clk_out=0, tick=0; pending applied. Re-enable starts from cnt=0, so the first rising clk_out edge comes active_div+1 cycles later.
- sync_clr=1 (priority over en and terminal count):
  - All channels: cnt=0, clk_out=0, tick=0, pending applied to active.
  - All enabled channels with equal divisors are then phase-aligned.
- Unsigned arithmetic; counter never exceeds active_div. If active_div is lowered below the current cnt, that is impossible by construction because updates happen only at terminal count or while disabled.
- Reset asserted mid-period: immediate return to reset values, no tick emitted.

Optional Feature:
- Macro TICK_CNT_EN.
- Defined:
  - Per-channel TCNT_W free-running counter increments on every tick, wraps at 2^TCNT_W to 0.
  - Cleared by reset and sync_clr; held, not cleared, while en=0.
  - Output on tick_cnt, same cycle as tick.
- Undefined: tick_cnt port and its counters are absent; all other behaviour identical.

Decomposition:
- Package clk_div_pkg holds:
  - CNT_W, DIV_DEFAULT and TCNT_W defaults.
  - Localparam for packed slice width.
  - Helper function computing divisor from target frequency, (f_clk/(2*f_out))-1, for elaboration-time constants.
- Sub-module clk_div_ch implements one channel (counter, pending/active divisor, clk_out, tick, optional tick counter).
- Top instantiates NUM_CH copies in a generate loop and unpacks div_in.

Test Plan:
- Reset default: release rst, en=all 1 -> every clk_out period 1502 cycles, tick every 751 cycles, first tick at cycle 751 after release.
- Div change: ch0 div_load with div_in=4 mid-period -> current half-period completes at 751, then ticks every 5 cycles, clk_out period 10; no half-period other than 751 or 5.
- Divisor zero: ch1 div=0 -> tick constantly 1, clk_out toggles every cycle.
- Enable gating: drop en[2] while clk_out[2]=1 -> next cycle clk_out=0, tick=0. Re-enable with div=3 -> first tick 4 cycles later.
- sync_clr: ch0 and ch3 at div=9 with random phase, pulse sync_clr -> both outputs identical thereafter, first tick 10 cycles after the clear. Async rst pulse mid-count -> outputs 0 immediately, before the next clk edge.
- TICK_CNT_EN: TCNT_W=4, div=0 -> tick_cnt counts 1..15 and wraps to 0 on the 16th tick; sync_clr -> 0.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared defaults, types and helpers for the multi-channel clock divider.
// Optional feature macro: TICK_CNT_EN (per-channel tick counters on tick_cnt).
package clk_div_pkg;

    // Default geometry of the divider block.
    localparam int CLK_DIV_NUM_CH  = 4;
    localparam int CLK_DIV_CNT_W   = 10;
    localparam int CLK_DIV_DEFAULT = 750;
    localparam int CLK_DIV_TCNT_W  = 16;

    // Width of one channel's slice inside the packed div_in bus.
    localparam int CLK_DIV_SLICE_W = CLK_DIV_CNT_W;

    // What a channel does on the next clock edge.
    typedef enum logic [1:0] {
        CH_CLEAR    = 2'd0,  // disabled or sync_clr: park at cnt=0, outputs low
        CH_TERMINAL = 2'd1,  // cnt reached active_div: wrap, toggle, tick
        CH_COUNT    = 2'd2   // mid-period: increment
    } ch_step_e;

    // Divisor giving f_out from f_clk: toggle period is 2*(div+1) cycles.
    // Intended for elaboration-time constants; returns 0 for unreachable rates.
    function automatic int div_from_freq(input longint unsigned f_clk,
                                         input longint unsigned f_out);
        if (f_out == 0 || f_clk < 2 * f_out) begin
            return 0;
        end
        return int'(f_clk / (2 * f_out)) - 1;
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: counter, pending/active divisor, 50% clock, tick strobe.
// Optional feature macro: TICK_CNT_EN adds a wrapping tick counter on tick_cnt.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = CLK_DIV_CNT_W,
    parameter int DIV_DEFAULT = CLK_DIV_DEFAULT,
    parameter int TCNT_W      = CLK_DIV_TCNT_W
) (
    input  logic             clk,
    input  logic             rst,        // asynchronous, active low
    input  logic             en,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_load,
    input  logic             sync_clr,
    output logic             clk_out,
    output logic             tick
`ifdef TICK_CNT_EN
    ,
    output logic [TCNT_W-1:0] tick_cnt
`endif
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_active_div;
    logic [CNT_W-1:0] r_pending_div;
    logic             r_clk_out;
    logic             r_tick;

    logic [CNT_W-1:0] w_pending_eff;
    logic             w_terminal;
    ch_step_e         w_step;

    // A load strobe arriving on the same edge the divisor is adopted wins,
    // so the freshly written value takes effect for the very next period.
    assign w_pending_eff = div_load ? div_in : r_pending_div;

    // ">=" rather than "==" so a corrupted counter can never run away;
    // in normal operation the counter never passes active_div.
    assign w_terminal = (r_cnt >= r_active_div);

    // Decide the channel's next step; sync_clr outranks en, en outranks counting.
    always_comb begin
        w_step = CH_COUNT;
        if (sync_clr || !en) begin
            w_step = CH_CLEAR;
        end else if (w_terminal) begin
            w_step = CH_TERMINAL;
        end
    end

    // Pending divisor register: last div_load strobe before adoption wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending_div <= DIV_RST;
        end else if (div_load) begin
            r_pending_div <= div_in;
        end
    end

    // Counter, active divisor and registered outputs. The active divisor only
    // changes at a period boundary or while parked, keeping half-periods whole.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt        <= '0;
            r_active_div <= DIV_RST;
            r_clk_out    <= 1'b0;
            r_tick       <= 1'b0;
        end else begin
            unique case (w_step)
                CH_CLEAR: begin
                    r_cnt        <= '0;
                    r_active_div <= w_pending_eff;
                    r_clk_out    <= 1'b0;
                    r_tick       <= 1'b0;
                end
                CH_TERMINAL: begin
                    r_cnt        <= '0;
                    r_active_div <= w_pending_eff;
                    r_clk_out    <= ~r_clk_out;
                    r_tick       <= 1'b1;
                end
                default: begin
                    r_cnt        <= r_cnt + 1'b1;
                    r_tick       <= 1'b0;
                end
            endcase
        end
    end

    assign clk_out = r_clk_out;
    assign tick    = r_tick;

`ifdef TICK_CNT_EN
    logic [TCNT_W-1:0] r_tick_cnt;

    // Free-running tick count: bumps on the same edge that raises tick,
    // wraps naturally, holds while disabled and clears on sync_clr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tick_cnt <= '0;
        end else if (sync_clr) begin
            r_tick_cnt <= '0;
        end else if (en && w_terminal) begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    assign tick_cnt = r_tick_cnt;
`endif

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel clock divider: NUM_CH independent 50%-duty clocks and ticks.
// Optional feature macro: TICK_CNT_EN exposes per-channel tick counters.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = CLK_DIV_NUM_CH,
    parameter int CNT_W       = CLK_DIV_CNT_W,
    parameter int DIV_DEFAULT = CLK_DIV_DEFAULT,
    parameter int TCNT_W      = CLK_DIV_TCNT_W
) (
    input  logic                    clk,
    input  logic                    rst,       // asynchronous, active low
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH*CNT_W-1:0] div_in,
    input  logic [NUM_CH-1:0]       div_load,
    input  logic                    sync_clr,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick
`ifdef TICK_CNT_EN
    ,
    output logic [NUM_CH*TCNT_W-1:0] tick_cnt
`endif
);

    // Unpacked view of the divisor bus, one entry per channel.
    logic [CNT_W-1:0] w_div_slice [NUM_CH];

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign w_div_slice[gi] = div_in[gi*CNT_W +: CNT_W];

            clk_div_ch #(
                .CNT_W       (CNT_W),
                .DIV_DEFAULT (DIV_DEFAULT),
                .TCNT_W      (TCNT_W)
            ) u_ch (
                .clk      (clk),
                .rst      (rst),
                .en       (en[gi]),
                .div_in   (w_div_slice[gi]),
                .div_load (div_load[gi]),
                .sync_clr (sync_clr),
                .clk_out  (clk_out[gi]),
                .tick     (tick[gi])
`ifdef TICK_CNT_EN
                ,
                .tick_cnt (tick_cnt[gi*TCNT_W +: TCNT_W])
`endif
            );
        end
    endgenerate

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi (default parameters, TCNT_W=4).
module tb_clk_div_multi;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 10;
    localparam int TCNT_W = 4;

    logic                    clk;
    logic                    rst;
    logic [NUM_CH-1:0]       en;
    logic [NUM_CH*CNT_W-1:0] div_in;
    logic [NUM_CH-1:0]       div_load;
    logic                    sync_clr;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       tick;
`ifdef TICK_CNT_EN
    logic [NUM_CH*TCNT_W-1:0] tick_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    clk_div_multi #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DIV_DEFAULT (750),
        .TCNT_W      (TCNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div_in   (div_in),
        .div_load (div_load),
        .sync_clr (sync_clr),
        .clk_out  (clk_out),
        .tick     (tick)
`ifdef TICK_CNT_EN
        ,
        .tick_cnt (tick_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: outputs are sampled and inputs driven 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Count edges until tick[ch] is seen high, giving up after bound edges.
    task automatic wait_tick(input int ch, input int bound, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!tick[ch] && n < bound);
    endtask

    // Single-cycle div_load strobe writing value into every channel in mask.
    task automatic load_div(input logic [NUM_CH-1:0] mask, input int value);
        for (int c = 0; c < NUM_CH; c++) begin
            if (mask[c]) div_in[c*CNT_W +: CNT_W] = CNT_W'(value);
        end
        div_load = mask;
        cyc();
        div_load = '0;
    endtask

    initial begin
        int n;
        int total;
        logic exp_clk;
        logic found;

        rst      = 1'b0;
        en       = '0;
        div_in   = '0;
        div_load = '0;
        sync_clr = 1'b0;

        // Reset state
        repeat (3) cyc();
        check("rst_clk_out", clk_out, 4'h0);
        check("rst_tick", tick, 4'h0);
        $display("[TB] reset held: clk_out=%b tick=%b", clk_out, tick);

        // Default divisor: first tick 751 edges after release, then every 751
        rst = 1'b1;
        en  = 4'hF;
        wait_tick(0, 2000, n);
        check("first_tick_lat", n, 751);
        check("first_tick_all", tick, 4'hF);
        check("first_clk_all", clk_out, 4'hF);
        $display("[TB] default first tick after %0d cycles", n);
        wait_tick(0, 2000, n);
        check("second_tick_lat", n, 751);
        check("second_clk_all", clk_out, 4'h0);
        cyc();
        check("tick_one_cycle", tick, 4'h0);

        // Divisor change on ch0 mid-period: current half-period still 751
        repeat (99) cyc();
        load_div(4'b0001, 4);
        wait_tick(0, 2000, n);
        total = 101 + n;
        check("div_chg_boundary", total, 751);
        check("div_chg_clk0", clk_out[0], 1'b1);
        $display("[TB] ch0 load div=4, half-period completed at %0d", total);
        exp_clk = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_tick(0, 100, n);
            exp_clk = ~exp_clk;
            check("div4_interval", n, 5);
            check("div4_clk0", clk_out[0], exp_clk);
            $display("[TB] ch0 tick interval %0d clk_out=%b", n, clk_out[0]);
        end

        // Divisor zero on ch1: adopted at its next terminal count
        load_div(4'b0010, 0);
        wait_tick(1, 800, n);
        check("ch1_tc_seen", tick[1], 1'b1);
        exp_clk = clk_out[1];
        for (int k = 0; k < 4; k++) begin
            cyc();
            exp_clk = ~exp_clk;
            check("div0_tick", tick[1], 1'b1);
            check("div0_clk", clk_out[1], exp_clk);
        end
        $display("[TB] ch1 div=0 tick stuck high, clk toggling");

        // Enable gating on ch2 while its clock is high
        found = 1'b0;
        for (int k = 0; k < 2000 && !found; k++) begin
            cyc();
            if (clk_out[2]) found = 1'b1;
        end
        check("ch2_hi_wait", found, 1'b1);
        en[2] = 1'b0;
        for (int c = 0; c < NUM_CH; c++) if (c == 2) div_in[c*CNT_W +: CNT_W] = 10'd3;
        div_load = 4'b0100;
        cyc();
        div_load = '0;
        check("dis_clk2", clk_out[2], 1'b0);
        check("dis_tick2", tick[2], 1'b0);
        repeat (2) cyc();
        check("dis_hold_clk2", clk_out[2], 1'b0);
        en[2] = 1'b1;
        wait_tick(2, 100, n);
        check("reen_first_tick", n, 4);
        check("reen_clk2_rise", clk_out[2], 1'b1);
        wait_tick(2, 100, n);
        check("reen_second_tick", n, 4);
        check("reen_clk2_fall", clk_out[2], 1'b0);
        $display("[TB] ch2 gated and re-enabled with div=3");

        // sync_clr aligns ch0 and ch3 at div=9
        load_div(4'b1001, 9);
        repeat ($urandom_range(3, 30)) cyc();
        sync_clr = 1'b1;
        cyc();
        sync_clr = 1'b0;
        check("sclr_clk_out", clk_out, 4'h0);
        check("sclr_tick", tick, 4'h0);
        wait_tick(0, 100, n);
        check("sclr_first_tick", n, 10);
        check("sclr_tick3", tick[3], 1'b1);
        exp_clk = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            cyc();
            if (k % 10 == 0) exp_clk = ~exp_clk;
            check("sclr_tick0", tick[0], (k % 10 == 0));
            check("sclr_tick3", tick[3], (k % 10 == 0));
            check("sclr_clk0", clk_out[0], exp_clk);
            check("sclr_clk3", clk_out[3], exp_clk);
        end
        $display("[TB] sync_clr aligned ch0/ch3, first tick after %0d", n);

`ifdef TICK_CNT_EN
        // Tick counter on ch1 (div=0): counts every cycle, wraps at 16
        sync_clr = 1'b1;
        cyc();
        sync_clr = 1'b0;
        check("tcnt_clr", tick_cnt[1*TCNT_W +: TCNT_W], 4'd0);
        for (int k = 1; k <= 16; k++) begin
            cyc();
            check("tcnt_count", tick_cnt[1*TCNT_W +: TCNT_W], TCNT_W'(k));
        end
        cyc();
        check("tcnt_after_wrap", tick_cnt[1*TCNT_W +: TCNT_W], 4'd1);
        en[1] = 1'b0;
        repeat (2) cyc();
        check("tcnt_hold_dis", tick_cnt[1*TCNT_W +: TCNT_W], 4'd1);
        en[1] = 1'b1;
        sync_clr = 1'b1;
        cyc();
        sync_clr = 1'b0;
        check("tcnt_sclr", tick_cnt[1*TCNT_W +: TCNT_W], 4'd0);
        $display("[TB] tick counter wrap and clear exercised");
`endif

        // Asynchronous reset mid-count: outputs drop before the next edge
        cyc();
        check("pre_rst_tick1", tick[1], 1'b1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_tick", tick, 4'h0);
        check("async_rst_clk", clk_out, 4'h0);
        cyc();
        rst = 1'b1;
        wait_tick(0, 2000, n);
        check("post_rst_default", n, 751);
        $display("[TB] async reset restored default divisor, tick after %0d", n);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
